// File: rtl/store_align_if.sv
// Store request / memory write bus for store_align.
// The master drives requests and out_ready; the slave (store_align) formats and returns writes.
interface store_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;

  modport master (
    output in_valid, in_addr, in_wdata, in_size, out_ready,
    input  in_ready, out_valid, out_addr, out_wdata, out_be
  );

  modport slave (
    input  in_valid, in_addr, in_wdata, in_size, out_ready,
    output in_ready, out_valid, out_addr, out_wdata, out_be
  );
endinterface

// File: rtl/store_align.sv
// MEM-stage store formatter: SB/SH/SW -> word address, lane-replicated data, byte enables,
// behind a 2-entry output/skid buffer. Optional misalign trap: STORE_MISALIGN_TRAP_EN.

// One byte lane: picks its data byte and enable from the effective store size.
module store_align_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size_eff,
  input  logic [1:0] addr_lo,
  input  logic [7:0] b_src,
  input  logic [7:0] h_src,
  input  logic [7:0] w_src,
  output logic [7:0] lane_data,
  output logic       lane_be
);
  localparam logic [1:0] LID = LANE[1:0];

  always_comb begin
    lane_data = w_src;
    lane_be   = 1'b1;
    case (size_eff)
      2'b00: begin
        lane_data = b_src;
        lane_be   = (addr_lo == LID);
      end
      2'b01: begin
        lane_data = h_src;
        lane_be   = (addr_lo[1] == LID[1]);
      end
      default: begin
        lane_data = w_src;
        lane_be   = 1'b1;
      end
    endcase
  end
endmodule

module store_align #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  store_align_if.slave     bus,
  output logic             misalign,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] store_cnt
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [NUM_LANES-1:0] be;
  } wr_req_t;

  // state[0] = output register valid, state[1] = skid valid
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } buf_state_t;

  buf_state_t state, nxt;
  wr_req_t    fmt, out_q, skid_q;
  logic [1:0] size_eff;
  logic       legal, accept, push;
  logic       ld_out, ld_skid, skid2out;
  logic [NUM_LANES-1:0][7:0] lane_data;
  logic [NUM_LANES-1:0]      lane_be;

`ifdef STORE_MISALIGN_TRAP_EN
  assign size_eff = bus.in_size;
  always_comb begin
    legal = 1'b0;
    case (bus.in_size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~bus.in_addr[0];
      2'b10:   legal = (bus.in_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end
`else
  // Without the trap, low address bits are ignored and size 11 stores a full word.
  assign size_eff = (bus.in_size == 2'b11) ? 2'b10 : bus.in_size;
  assign legal    = 1'b1;
`endif

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      store_align_lane #(.LANE(l)) u_lane (
        .size_eff  (size_eff),
        .addr_lo   (bus.in_addr[1:0]),
        .b_src     (bus.in_wdata[7:0]),
        .h_src     (bus.in_wdata[8*(l%2) +: 8]),
        .w_src     (bus.in_wdata[8*l +: 8]),
        .lane_data (lane_data[l]),
        .lane_be   (lane_be[l])
      );
    end
  endgenerate

  assign fmt.addr  = {bus.in_addr[31:2], 2'b00};
  assign fmt.wdata = lane_data;
  assign fmt.be    = lane_be;

  // Both handshake outputs are direct flop bits, so in_ready never sees out_ready.
  assign bus.in_ready  = ~state[1];
  assign bus.out_valid = state[0];
  assign bus.out_addr  = out_q.addr;
  assign bus.out_wdata = out_q.wdata;
  assign bus.out_be    = out_q.be;

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & legal;

  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    ld_out   = 1'b0;
    ld_skid  = 1'b0;
    skid2out = 1'b0;
    case (state)
      S_EMPTY: begin
        if (push) begin
          ld_out = 1'b1;
          nxt    = S_ONE;
        end
      end
      S_ONE: begin
        if (push) begin
          if (bus.out_ready) begin
            ld_out = 1'b1;
          end else begin
            ld_skid = 1'b1;
            nxt     = S_TWO;
          end
        end else if (bus.out_ready) begin
          nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (bus.out_ready) begin
          skid2out = 1'b1;
          nxt      = S_ONE;
        end
      end
      default: nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (skid2out)    out_q <= skid_q;
      else if (ld_out) out_q <= fmt;
      if (ld_skid)     skid_q <= fmt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             store_cnt <= '0;
    else if (bus.out_valid & bus.out_ready) store_cnt <= store_cnt + 1'b1;
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= accept & ~legal;
      if (accept & ~legal) misalign_addr <= bus.in_addr;
    end
  end
`else
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif
endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: lanes, sizes, backpressure, misalign, reset, counter wrap.
module tb_store_align;
  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic        misalign, misalign2;
  logic [31:0] misalign_addr, misalign_addr2;
  logic [15:0] store_cnt;
  logic [1:0]  store_cnt2;

  store_align_if sif ();
  store_align_if sif2 ();

  store_align #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (sif),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .store_cnt     (store_cnt)
  );

  store_align #(.CNT_W(2)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .bus           (sif2),
    .misalign      (misalign2),
    .misalign_addr (misalign_addr2),
    .store_cnt     (store_cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    sif.in_valid = v;
    sif.in_size  = sz;
    sif.in_addr  = a;
    sif.in_wdata = d;
  endtask

  task automatic do_reset;
    req(1'b0, 2'b00, 32'h0, 32'h0);
    sif.out_ready  = 1'b1;
    sif2.in_valid  = 1'b0;
    sif2.in_size   = 2'b10;
    sif2.in_addr   = 32'h0;
    sif2.in_wdata  = 32'h0;
    sif2.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({sif.out_valid, sif.in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_handshake: got %b exp 01", {sif.out_valid, sif.in_ready});
    end
    checks++;
    if ({sif.out_addr, sif.out_wdata, sif.out_be} !== 68'h0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", {sif.out_addr, sif.out_wdata, sif.out_be});
    end
    checks++;
    if ({misalign, misalign_addr, store_cnt} !== 49'h0) begin
      errors++; $display("FAIL reset_status: got %h exp 0", {misalign, misalign_addr, store_cnt});
    end
  endtask

  task automatic test_byte_lanes;
    logic [3:0] be_exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 2'b00, 32'h1000 + i, 32'h123456AB);
      tick();
      be_exp = 4'b0001 << i;
      checks++;
      if ({sif.out_valid, sif.out_addr, sif.out_wdata, sif.out_be} !== {1'b1, 32'h1000, 32'hABABABAB, be_exp}) begin
        errors++; $display("FAIL byte_lane%0d: got v=%b a=%h d=%h be=%b exp v=1 a=00001000 d=abababab be=%b",
                           i, sif.out_valid, sif.out_addr, sif.out_wdata, sif.out_be, be_exp);
      end
    end
    req(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    checks++;
    if ({sif.out_valid, store_cnt} !== {1'b0, 16'd4}) begin
      errors++; $display("FAIL byte_cnt: got v=%b cnt=%0d exp v=0 cnt=4", sif.out_valid, store_cnt);
    end
  endtask

  task automatic test_half_word;
    do_reset();
    req(1'b1, 2'b01, 32'h2002, 32'h0000BEEF);
    tick();
    checks++;
    if ({sif.out_addr, sif.out_wdata, sif.out_be} !== {32'h2000, 32'hBEEFBEEF, 4'b1100}) begin
      errors++; $display("FAIL half_hi: got a=%h d=%h be=%b exp a=00002000 d=beefbeef be=1100",
                         sif.out_addr, sif.out_wdata, sif.out_be);
    end
    req(1'b1, 2'b01, 32'h2000, 32'hA5A5CAFE);
    tick();
    checks++;
    if ({sif.out_addr, sif.out_wdata, sif.out_be} !== {32'h2000, 32'hCAFECAFE, 4'b0011}) begin
      errors++; $display("FAIL half_lo: got a=%h d=%h be=%b exp a=00002000 d=cafecafe be=0011",
                         sif.out_addr, sif.out_wdata, sif.out_be);
    end
    req(1'b1, 2'b10, 32'h2004, 32'hDEADBEEF);
    tick();
    checks++;
    if ({sif.out_addr, sif.out_wdata, sif.out_be} !== {32'h2004, 32'hDEADBEEF, 4'b1111}) begin
      errors++; $display("FAIL word: got a=%h d=%h be=%b exp a=00002004 d=deadbeef be=1111",
                         sif.out_addr, sif.out_wdata, sif.out_be);
    end
    req(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    checks++;
    if (store_cnt !== 16'd3) begin
      errors++; $display("FAIL half_word_cnt: got %0d exp 3", store_cnt);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    sif.out_ready = 1'b0;
    req(1'b1, 2'b10, 32'h0, 32'h11111111);
    tick();
    checks++;
    if ({sif.out_valid, sif.in_ready, sif.out_wdata} !== {2'b11, 32'h11111111}) begin
      errors++; $display("FAIL bp_first: got v=%b rdy=%b d=%h exp v=1 rdy=1 d=11111111",
                         sif.out_valid, sif.in_ready, sif.out_wdata);
    end
    req(1'b1, 2'b10, 32'h4, 32'h22222222);
    tick();
    checks++;
    if ({sif.out_valid, sif.in_ready, sif.out_wdata} !== {2'b10, 32'h11111111}) begin
      errors++; $display("FAIL bp_full: got v=%b rdy=%b d=%h exp v=1 rdy=0 d=11111111",
                         sif.out_valid, sif.in_ready, sif.out_wdata);
    end
    // Offered while full: must not be accepted.
    req(1'b1, 2'b10, 32'h8, 32'h33333333);
    tick();
    checks++;
    if ({sif.in_ready, sif.out_addr, sif.out_wdata} !== {1'b0, 32'h0, 32'h11111111}) begin
      errors++; $display("FAIL bp_hold: got rdy=%b a=%h d=%h exp rdy=0 a=00000000 d=11111111",
                         sif.in_ready, sif.out_addr, sif.out_wdata);
    end
    req(1'b0, 2'b00, 32'h0, 32'h0);
    sif.out_ready = 1'b1;
    tick();
    checks++;
    if ({sif.out_valid, sif.in_ready, sif.out_addr, sif.out_wdata, store_cnt} !==
        {2'b11, 32'h4, 32'h22222222, 16'd1}) begin
      errors++; $display("FAIL bp_drain1: got v=%b rdy=%b a=%h d=%h cnt=%0d exp v=1 rdy=1 a=00000004 d=22222222 cnt=1",
                         sif.out_valid, sif.in_ready, sif.out_addr, sif.out_wdata, store_cnt);
    end
    tick();
    checks++;
    if ({sif.out_valid, sif.in_ready, store_cnt} !== {2'b01, 16'd2}) begin
      errors++; $display("FAIL bp_drain2: got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=2",
                         sif.out_valid, sif.in_ready, store_cnt);
    end
  endtask

  task automatic test_misalign;
    do_reset();
    req(1'b1, 2'b10, 32'h3001, 32'hCAFEF00D);
    tick();
`ifdef STORE_MISALIGN_TRAP_EN
    checks++;
    if ({misalign, misalign_addr, sif.out_valid} !== {1'b1, 32'h3001, 1'b0}) begin
      errors++; $display("FAIL mis_word: got m=%b ma=%h v=%b exp m=1 ma=00003001 v=0",
                         misalign, misalign_addr, sif.out_valid);
    end
    req(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    checks++;
    if ({misalign, misalign_addr, sif.out_valid, store_cnt} !== {1'b0, 32'h3001, 1'b0, 16'd0}) begin
      errors++; $display("FAIL mis_pulse: got m=%b ma=%h v=%b cnt=%0d exp m=0 ma=00003001 v=0 cnt=0",
                         misalign, misalign_addr, sif.out_valid, store_cnt);
    end
    req(1'b1, 2'b11, 32'h3004, 32'h0);
    tick();
    checks++;
    if ({misalign, misalign_addr, sif.out_valid} !== {1'b1, 32'h3004, 1'b0}) begin
      errors++; $display("FAIL mis_size11: got m=%b ma=%h v=%b exp m=1 ma=00003004 v=0",
                         misalign, misalign_addr, sif.out_valid);
    end
    req(1'b1, 2'b01, 32'h3003, 32'h0);
    tick();
    checks++;
    if ({misalign, misalign_addr, sif.out_valid} !== {1'b1, 32'h3003, 1'b0}) begin
      errors++; $display("FAIL mis_half: got m=%b ma=%h v=%b exp m=1 ma=00003003 v=0",
                         misalign, misalign_addr, sif.out_valid);
    end
`else
    checks++;
    if ({misalign, sif.out_valid, sif.out_addr, sif.out_wdata, sif.out_be} !==
        {2'b01, 32'h3000, 32'hCAFEF00D, 4'b1111}) begin
      errors++; $display("FAIL nomis_word: got m=%b v=%b a=%h d=%h be=%b exp m=0 v=1 a=00003000 d=cafef00d be=1111",
                         misalign, sif.out_valid, sif.out_addr, sif.out_wdata, sif.out_be);
    end
    req(1'b1, 2'b11, 32'h3006, 32'h89ABCDEF);
    tick();
    checks++;
    if ({misalign, sif.out_addr, sif.out_wdata, sif.out_be} !== {1'b0, 32'h3004, 32'h89ABCDEF, 4'b1111}) begin
      errors++; $display("FAIL nomis_size11: got m=%b a=%h d=%h be=%b exp m=0 a=00003004 d=89abcdef be=1111",
                         misalign, sif.out_addr, sif.out_wdata, sif.out_be);
    end
    req(1'b1, 2'b01, 32'h3003, 32'h00001234);
    tick();
    checks++;
    if ({misalign, sif.out_addr, sif.out_wdata, sif.out_be} !== {1'b0, 32'h3000, 32'h12341234, 4'b1100}) begin
      errors++; $display("FAIL nomis_half: got m=%b a=%h d=%h be=%b exp m=0 a=00003000 d=12341234 be=1100",
                         misalign, sif.out_addr, sif.out_wdata, sif.out_be);
    end
    req(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    checks++;
    if ({misalign_addr, store_cnt} !== {32'h0, 16'd3}) begin
      errors++; $display("FAIL nomis_cnt: got ma=%h cnt=%0d exp ma=00000000 cnt=3", misalign_addr, store_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset();
    sif.out_ready = 1'b0;
    req(1'b1, 2'b10, 32'h40, 32'h55555555);
    tick();
    req(1'b1, 2'b10, 32'h44, 32'h66666666);
    tick();
    req(1'b0, 2'b00, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({sif.out_valid, sif.in_ready, store_cnt, sif.out_be} !== {2'b01, 16'd0, 4'b0000}) begin
      errors++; $display("FAIL rst_mid: got v=%b rdy=%b cnt=%0d be=%b exp v=0 rdy=1 cnt=0 be=0000",
                         sif.out_valid, sif.in_ready, store_cnt, sif.out_be);
    end
    sif.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({sif.out_valid, store_cnt} !== {1'b0, 16'd0}) begin
      errors++; $display("FAIL rst_mid_flush: got v=%b cnt=%0d exp v=0 cnt=0", sif.out_valid, store_cnt);
    end
  endtask

  task automatic test_cnt_wrap;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sif2.in_valid = 1'b1;
      sif2.in_size  = 2'b10;
      sif2.in_addr  = 32'h100 + 4 * i;
      sif2.in_wdata = 32'h1000 + i;
      tick();
    end
    sif2.in_valid = 1'b0;
    checks++;
    if (store_cnt2 !== 2'd0) begin
      errors++; $display("FAIL wrap_four: got %0d exp 0", store_cnt2);
    end
    tick();
    checks++;
    if ({sif2.out_valid, store_cnt2} !== {1'b0, 2'd1}) begin
      errors++; $display("FAIL wrap_five: got v=%b cnt=%0d exp v=0 cnt=1", sif2.out_valid, store_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_half_word();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
